// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Latency: busy for WIDTH cycles after the accepting edge, done pulses in cycle WIDTH+1.
// Backpressure: start is accepted only in IDLE/DONE (busy==0); start while busy is ignored.
//
// Ports:
//   clk, rst_n          - clock (rising edge), asynchronous active-low reset
//   start               - request, sampled on the rising edge when not busy
//   dividend, divisor   - unsigned operands, captured on the accepting edge
//   busy                - high while iterating
//   done                - one-cycle result strobe
//   quotient, remainder - results, held until the next operation completes
//   div_zero            - only with DIVZERO_FLAG_EN defined: divisor was zero
//
// Optional feature macro: DIVZERO_FLAG_EN. When defined, a zero divisor raises
// div_zero and skips the iteration, so done follows acceptance by one cycle
// and busy stays low.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIVZERO_FLAG_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] divisor_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] partial_rem;
    logic [CW-1:0]    cnt;

    // Shifted partial remainder; the bit shifted out of partial_rem stays on as
    // the extra MSB so the trial subtraction sees the full WIDTH+1-bit value.
    logic [WIDTH:0]   rem_shift;
    // Subtract-with-borrow via the adder chain: a + ~b + 1. The carry out of
    // the top bit is set exactly when there is no borrow.
    logic [WIDTH+1:0] sub_sum;
    logic             no_borrow;
    logic [WIDTH-1:0] next_rem;
    logic [WIDTH-1:0] next_q;
    logic             accept;
    logic             unused_trial_msb;

    assign rem_shift = {partial_rem, q_reg[WIDTH-1]};
    assign sub_sum   = {1'b0, rem_shift} + {1'b0, ~{1'b0, divisor_reg}} + (WIDTH+2)'(1);
    assign no_borrow = sub_sum[WIDTH+1];
    // With no borrow the trial result is below the divisor, so its top bit is
    // always zero and only the low WIDTH bits are kept.
    assign unused_trial_msb = sub_sum[WIDTH];
    assign next_rem  = no_borrow ? sub_sum[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign next_q    = {q_reg[WIDTH-2:0], no_borrow};
    assign accept    = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            divisor_reg <= '0;
            q_reg       <= '0;
            partial_rem <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
`ifdef DIVZERO_FLAG_EN
            div_zero    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (accept) begin
                state       <= CALC;
                divisor_reg <= divisor;
                q_reg       <= dividend;
                partial_rem <= '0;
                cnt         <= '0;
`ifdef DIVZERO_FLAG_EN
                div_zero    <= (divisor == '0);
                busy        <= (divisor != '0);
`else
                busy        <= 1'b1;
`endif
            end else begin
                case (state)
                    CALC: begin
`ifdef DIVZERO_FLAG_EN
                        if (div_zero) begin
                            // Zero divisor: q_reg still holds the untouched dividend.
                            state     <= DONE;
                            done      <= 1'b1;
                            quotient  <= '1;
                            remainder <= q_reg;
                        end else
`endif
                        begin
                            partial_rem <= next_rem;
                            q_reg       <= next_q;
                            cnt         <= cnt + CW'(1);
                            if (cnt == LAST) begin
                                state     <= DONE;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                quotient  <= next_q;
                                remainder <= next_rem;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle unsigned restoring divider. It is the inverse-direction companion to the team's combinational 8-bit ripple adder.
- Each iteration reuses a WIDTH-bit subtract-with-borrow. The borrow is the adder's carry chain with the subtrahend inverted and carry-in forced to 1.
- Serves the game datapath for mine-density, board-index to row/column conversion, and score-ratio math, where one result every few cycles is enough.
- Uses a start/done handshake, so there is no combinational path from operands to results.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder (minimum 2).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising edge; accepted only when busy==0
- dividend  input  WIDTH  unsigned dividend; captured on the accepting edge
- divisor  input  WIDTH  unsigned divisor; captured on the accepting edge
- busy  output  1  high while an operation iterates
- done  output  1  one-cycle pulse; results valid
- quotient  output  WIDTH  unsigned quotient; held until next accepted start
- remainder  output  WIDTH  unsigned remainder; held until next accepted start
- div_zero  output  1  present only when DIVZERO_FLAG_EN is defined

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: state=IDLE; busy=0; done=0; quotient=0; remainder=0; iteration counter=0; div_zero=0.
- States:
  - IDLE: waiting for a request.
  - CALC: iterating.
  - DONE: one-cycle result strobe.
- IDLE -> CALC: on the edge where start==1.
  - Latch the divisor.
  - Load the quotient shift register with the dividend.
  - Clear the partial remainder and counter.
- CALC, one iteration per cycle:
  - rem_shift = {partial_rem[WIDTH-2:0], q_reg[WIDTH-1]}. The shifted-out bit partial_rem[WIDTH-1] is kept as the (WIDTH+1)-th bit.
  - trial = (WIDTH+1)-bit {carry_out, rem_shift} minus {0, divisor}.
  - If there is no borrow: partial_rem = trial[WIDTH-1:0] and shift 1 into the q_reg LSB.
  - Otherwise: partial_rem = rem_shift and shift in 0.
  - q_reg shifts left each cycle.
  - The counter increments. After WIDTH iterations (counter==WIDTH-1 at the edge) go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - quotient/remainder outputs are updated on the edge entering DONE.
  - Next edge: go to IDLE, or directly to CALC if start==1 (back-to-back).
- Latency:
  - busy is high for exactly WIDTH cycles after the accepting edge.
  - done is high in cycle WIDTH+1.
  - busy and done are never high simultaneously.
- Handshake:
  - start while busy==1 is ignored; operands are not re-sampled.
  - start held high continuously produces one operation per WIDTH+1 cycles.
- Divisor == 0:
  - There is no special path; natural restoring behaviour gives quotient=all ones and remainder=dividend.
  - Latency is unchanged.
- Dividend < divisor: quotient=0, remainder=dividend.
- Operands changing after the accepting edge have no effect.
- Reset asserted mid-CALC: immediately return to IDLE with all outputs at reset values. The partial result is discarded, and no done is issued.
- Invariant: quotient*divisor + remainder == dividend and remainder < divisor, for divisor != 0.

Optional Feature:
- Macro: DIVZERO_FLAG_EN.
- Defined:
  - The div_zero output exists.
  - It is registered on the accepting edge as (divisor==0) and holds until the next accepted start.
  - When divisor==0 the block skips CALC and enters DONE on the next edge, so done appears 1 cycle after acceptance.
  - In that case quotient=all ones, remainder=dividend, and busy stays 0.
- Undefined:
  - No div_zero port.
  - Divide-by-zero takes the full WIDTH+1 latency with the same all-ones/dividend result.

Test Plan:
- 200/7, start for 1 cycle -> busy high 8 cycles, done in cycle 9; quotient=28, remainder=4.
- 255/1 then 5/9 back-to-back with start held -> results 255/0 then 0/5; done pulses exactly 9 cycles apart.
- Apply 100/10, then drive start with 50/3 at cycle 3 while busy -> second request ignored; result 10/0; outputs held until the next start.
- 77/0, macro off -> done at cycle 9; quotient=255, remainder=77. Macro on -> done at cycle 2, div_zero=1, busy never high.
- Start 200/7, assert rst_n=0 at cycle 4 -> outputs 0 asynchronously, no done. After release, 9/3 -> quotient=3, remainder=0.
- Random sweep of 2000 operand pairs, divisor != 0 -> invariant holds against a reference model.
